// File: rtl/base_red_xor_seq.sv
// Sequential XOR reduction of a multi-lane frame, folding `fold` lanes per cycle
// through a combinational reducer, with valid/ready handshakes on both sides.

module base_red_xor #(
  parameter int ways  = 2,
  parameter int width = 8
) (
  input  logic [ways*width-1:0] d,
  output logic [width-1:0]      q
);
  always_comb begin
    q = '0;
    for (int k = 0; k < ways; k++) q = q ^ d[k*width +: width];
  end
endmodule

module base_red_xor_seq #(
  parameter int ways  = 4,
  parameter int width = 8,
  parameter int fold  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_v,
  output logic                  i_r,
  input  logic [ways*width-1:0] i_d,
  output logic                  o_v,
  input  logic                  o_r,
  output logic [width-1:0]      o_d,
  output logic                  o_busy
);
  localparam int N  = ways / fold;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = fold * width;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_nxt;
  logic [ways*width-1:0] hold_p0;
  logic [width-1:0]      acc_p1;
  logic [CW-1:0]         cnt;
  logic [GW-1:0]         grp;
  logic [width-1:0]      grp_x;
  logic                  in_x, out_x, last;

  assign in_x  = i_v & i_r;
  assign out_x = o_v & o_r;
  assign last  = (cnt == CW'(N - 1));

  // Pick the lane group addressed by cnt; mux form keeps the index width-clean.
  always_comb begin
    grp = '0;
    for (int g = 0; g < N; g++)
      if (cnt == CW'(g)) grp = hold_p0[g*GW +: GW];
  end

  base_red_xor #(
    .ways  (fold),
    .width (width)
  ) u_red (
    .d (grp),
    .q (grp_x)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_x) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_x) state_nxt = i_v ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    i_r    = 1'b0;
    o_v    = 1'b0;
    o_busy = 1'b0;
    o_d    = '0;
    case (state)
      IDLE: i_r = 1'b1;
      RUN:  o_busy = 1'b1;
      DONE: begin
        i_r    = o_r;
        o_v    = 1'b1;
        o_busy = 1'b1;
        o_d    = acc_p1;
      end
      default: i_r = 1'b0;
    endcase
  end

  // Stage p0: frame capture. Back-to-back acceptance in DONE lands here too,
  // since i_r follows o_r there.
  // Stage p1: one lane group folded into the accumulator per RUN cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_p0 <= '0;
      acc_p1  <= '0;
      cnt     <= '0;
    end else if (in_x) begin
      hold_p0 <= i_d;
      acc_p1  <= '0;
      cnt     <= '0;
    end else if (state == RUN) begin
      acc_p1 <= acc_p1 ^ grp_x;
      cnt    <= last ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_base_red_xor_seq.sv
// Directed checks of base_red_xor_seq (fold=2 and fold=ways) plus a
// stalled random stream compared against a lane-XOR reference.

module tb_base_red_xor_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        i_v, i_r, o_v, o_r, o_busy;
  logic [31:0] i_d;
  logic [7:0]  o_d;
  logic        i_v4, i_r4, o_v4, o_r4, o_busy4;
  logic [31:0] i_d4;
  logic [7:0]  o_d4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  base_red_xor_seq #(.ways(4), .width(8), .fold(2)) dut (
    .clk(clk), .reset(reset), .i_v(i_v), .i_r(i_r), .i_d(i_d),
    .o_v(o_v), .o_r(o_r), .o_d(o_d), .o_busy(o_busy)
  );

  base_red_xor_seq #(.ways(4), .width(8), .fold(4)) dut4 (
    .clk(clk), .reset(reset), .i_v(i_v4), .i_r(i_r4), .i_d(i_d4),
    .o_v(o_v4), .o_r(o_r4), .o_d(o_d4), .o_busy(o_busy4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] refx(input logic [31:0] d);
    return d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
  endfunction

  initial begin
    logic [7:0] q[$];
    logic       ix, ox;
    logic [7:0] od;
    int         nin, nout, cyc;

    reset = 1'b1; i_v = 1'b0; o_r = 1'b0; i_d = '0;
    i_v4 = 1'b0; o_r4 = 1'b0; i_d4 = '0;
    tick; tick;
    chk("rst_ov", o_v, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_od", o_d, 0);
    chk("rst_ir", i_r, 1);
    reset = 1'b0;

    // Single frame, immediate drain
    i_d = 32'h04030201; i_v = 1'b1; o_r = 1'b1;
    tick;
    i_v = 1'b0;
    chk("f1_busy", o_busy, 1);
    chk("f1_ir_run", i_r, 0);
    chk("f1_ov_t0", o_v, 0);
    tick;
    chk("f1_ov_t1", o_v, 0);
    tick;
    chk("f1_ov_t2", o_v, 1);
    chk("f1_od", o_d, 8'h04);
    tick;
    chk("f1_idle_ov", o_v, 0);
    chk("f1_idle_busy", o_busy, 0);
    chk("f1_idle_od", o_d, 0);
    chk("f1_idle_ir", i_r, 1);

    // Output stall in DONE; input activity while i_r=0 must be ignored
    o_r = 1'b0; i_d = 32'h04030201; i_v = 1'b1;
    tick;
    i_d = 32'hFFFFFFFF;
    tick; tick;
    for (int k = 0; k < 5; k++) begin
      chk("st_ov", o_v, 1);
      chk("st_od", o_d, 8'h04);
      chk("st_ir", i_r, 0);
      tick;
    end
    i_v = 1'b0; o_r = 1'b1;
    #1;
    chk("st_ir_open", i_r, 1);
    tick;
    chk("st_done_ov", o_v, 0);
    chk("st_done_busy", o_busy, 0);
    tick;
    chk("st_single_ov", o_v, 0);

    // Back-to-back frames
    i_d = 32'hFF00FF00; i_v = 1'b1; o_r = 1'b1;
    tick;
    i_d = 32'h80402010;
    tick;
    chk("bb_run_ov", o_v, 0);
    tick;
    chk("bb_a_ov", o_v, 1);
    chk("bb_a_od", o_d, 8'h00);
    chk("bb_a_ir", i_r, 1);
    tick;
    i_v = 1'b0;
    chk("bb_b_run_ov", o_v, 0);
    chk("bb_b_busy", o_busy, 1);
    tick;
    chk("bb_b_run2_ov", o_v, 0);
    tick;
    chk("bb_b_ov", o_v, 1);
    chk("bb_b_od", o_d, 8'hF0);
    tick;
    chk("bb_end_ov", o_v, 0);
    chk("bb_end_busy", o_busy, 0);

    // ways == fold: one RUN cycle
    i_d4 = 32'h11223344; i_v4 = 1'b1; o_r4 = 1'b1;
    tick;
    i_v4 = 1'b0;
    chk("w4_run_ov", o_v4, 0);
    chk("w4_run_busy", o_busy4, 1);
    tick;
    chk("w4_ov", o_v4, 1);
    chk("w4_od", o_d4, 8'h44);
    tick;
    chk("w4_idle_ov", o_v4, 0);
    chk("w4_idle_od", o_d4, 0);

    // Reset mid-RUN
    i_d = 32'h12345678; i_v = 1'b1; o_r = 1'b1;
    tick;
    i_v = 1'b0;
    tick;
    reset = 1'b1;
    #1;
    chk("rr_ov", o_v, 0);
    chk("rr_busy", o_busy, 0);
    chk("rr_od", o_d, 0);
    chk("rr_ir", i_r, 1);
    tick;
    reset = 1'b0;
    tick;
    chk("rr_no_pulse", o_v, 0);
    i_d = 32'h01010101; i_v = 1'b1;
    tick;
    i_v = 1'b0;
    chk("rr_accept", o_busy, 1);
    tick; tick;
    chk("rr_f_ov", o_v, 1);
    chk("rr_f_od", o_d, 8'h00);
    tick;
    chk("rr_f_idle", o_busy, 0);

    // Reset while holding a result in DONE
    o_r = 1'b0; i_d = 32'h04030201; i_v = 1'b1;
    tick;
    i_v = 1'b0;
    tick; tick;
    chk("rd_ov_pre", o_v, 1);
    reset = 1'b1;
    #1;
    chk("rd_ov", o_v, 0);
    chk("rd_busy", o_busy, 0);
    tick;
    reset = 1'b0; o_r = 1'b1;
    tick;
    chk("rd_no_pulse0", o_v, 0);
    tick;
    chk("rd_no_pulse1", o_v, 0);

    // Random stream with stalls on both sides
    nin = 0; nout = 0; cyc = 0;
    while (nout < 300 && cyc < 20000) begin
      i_v = (nin < 300) && ($urandom_range(0, 3) != 0);
      i_d = $urandom;
      o_r = ($urandom_range(0, 3) != 0);
      #1;
      ix = i_v & i_r;
      ox = o_v & o_r;
      od = o_d;
      if (ox) begin
        if (q.size() == 0) chk("rnd_extra", q.size(), 1);
        else chk("rnd_od", od, q.pop_front());
        nout++;
      end
      if (ix) begin
        q.push_back(refx(i_d));
        nin++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    i_v = 1'b0;
    chk("rnd_count", nout, 300);
    chk("rnd_left", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
